// File: rtl/time_ascii_tx.sv
// Snapshots the BCD 12-hour time on start and streams it as an ASCII frame over valid/ready.
// Define TIME_ASCII_TX_CRLF_EN to append CR LF to each frame (13 bytes instead of 11).
//
// state | meaning
// IDLE  | waiting for start; tx_valid low
// SEND  | presenting snapshot byte idx; advances on tx_valid && tx_ready
module time_ascii_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       busy,
    output logic       overrun
);

`ifdef TIME_ASCII_TX_CRLF_EN
    localparam logic [3:0] LAST_IDX = 4'd12;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t     state, state_n;
    logic [3:0] idx, idx_n;
    logic [7:0] snap_hh, snap_hh_n;
    logic [7:0] snap_mm, snap_mm_n;
    logic [7:0] snap_ss, snap_ss_n;
    logic       snap_pm, snap_pm_n;
    logic [7:0] tx_data_n;
    logic       tx_last_n;
    logic       overrun_n;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 | {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] byte_at(
        input logic [3:0] i,
        input logic [7:0] h,
        input logic [7:0] m,
        input logic [7:0] s,
        input logic       p
    );
        logic [7:0] b;
        b = 8'h00;
        case (i)
            4'd0:  b = (h[7:4] == 4'h0) ? 8'h20 : digit(h[7:4]);
            4'd1:  b = digit(h[3:0]);
            4'd2:  b = 8'h3A;
            4'd3:  b = digit(m[7:4]);
            4'd4:  b = digit(m[3:0]);
            4'd5:  b = 8'h3A;
            4'd6:  b = digit(s[7:4]);
            4'd7:  b = digit(s[3:0]);
            4'd8:  b = 8'h20;
            4'd9:  b = p ? 8'h50 : 8'h41;
            4'd10: b = 8'h4D;
`ifdef TIME_ASCII_TX_CRLF_EN
            4'd11: b = 8'h0D;
            4'd12: b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            snap_hh <= 8'h00;
            snap_mm <= 8'h00;
            snap_ss <= 8'h00;
            snap_pm <= 1'b0;
            tx_data <= 8'h00;
            tx_last <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            snap_hh <= snap_hh_n;
            snap_mm <= snap_mm_n;
            snap_ss <= snap_ss_n;
            snap_pm <= snap_pm_n;
            tx_data <= tx_data_n;
            tx_last <= tx_last_n;
            overrun <= overrun_n;
        end
    end

    // tx_data/tx_last are loaded with the byte for the index being entered,
    // so the outputs come straight from flops.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        snap_hh_n = snap_hh;
        snap_mm_n = snap_mm;
        snap_ss_n = snap_ss;
        snap_pm_n = snap_pm;
        tx_data_n = tx_data;
        tx_last_n = tx_last;
        overrun_n = (state == SEND) && start;

        case (state)
            IDLE: begin
                if (start) begin
                    snap_hh_n = hh;
                    snap_mm_n = mm;
                    snap_ss_n = ss;
                    snap_pm_n = pm;
                    idx_n     = 4'd0;
                    tx_data_n = byte_at(4'd0, hh, mm, ss, pm);
                    tx_last_n = 1'b0;
                    state_n   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_n     = 4'd0;
                        tx_data_n = 8'h00;
                        tx_last_n = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        idx_n     = idx + 4'd1;
                        tx_data_n = byte_at(idx + 4'd1, snap_hh, snap_mm, snap_ss, snap_pm);
                        tx_last_n = ((idx + 4'd1) == LAST_IDX);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx_valid = (state == SEND);
    assign busy     = (state == SEND);

endmodule

// File: tb/tb_time_ascii_tx.sv
// Directed and randomized frames for time_ascii_tx, checked against a text-level frame model.
// Honours TIME_ASCII_TX_CRLF_EN to pick the expected frame length.
module tb_time_ascii_tx;

`ifdef TIME_ASCII_TX_CRLF_EN
    localparam int N = 13;
`else
    localparam int N = 11;
`endif
    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       reset, start, pm, tx_ready;
    logic [7:0] hh, mm, ss;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, busy, overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    time_ascii_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .pm       (pm),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] ascii_digit(input int n);
        return (n < 10) ? 8'(48 + n) : 8'h3F;
    endfunction

    // Expected text of one frame, e.g. "12:00:00 AM" plus optional CR LF.
    task automatic build(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        int ht;
        ht = int'(h) / 16;
        exp_q.delete();
        exp_q.push_back((ht == 0) ? 8'h20 : ascii_digit(ht));
        exp_q.push_back(ascii_digit(int'(h) % 16));
        exp_q.push_back(8'h3A);
        exp_q.push_back(ascii_digit(int'(m) / 16));
        exp_q.push_back(ascii_digit(int'(m) % 16));
        exp_q.push_back(8'h3A);
        exp_q.push_back(ascii_digit(int'(s) / 16));
        exp_q.push_back(ascii_digit(int'(s) % 16));
        exp_q.push_back(8'h20);
        exp_q.push_back(p ? 8'h50 : 8'h41);
        exp_q.push_back(8'h4D);
        if (N == 13) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic run_frame(
        input  logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p,
        input  bit rnd_ready, input int stall_idx, input int ovr_idx, input bit ovr_last,
        input  int rst_idx, output int cycles
    );
        int  k;
        int  stall_left;
        bit  ovr_expect;
        bit  ovr_done;
        bit  xfer;
        bit  aborted;
        k = 0; cycles = 0; stall_left = 3; ovr_expect = 0; ovr_done = 0; aborted = 0;
        build(h, m, s, p);
        hh = h; mm = m; ss = s; pm = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (k < N && cycles < LIMIT) begin
            chk("tx_valid", int'(tx_valid), 1);
            chk("busy", int'(busy), 1);
            chk($sformatf("tx_data[%0d]", k), int'(tx_data), int'(exp_q[k]));
            chk($sformatf("tx_last[%0d]", k), int'(tx_last), int'(k == N - 1));
            chk("overrun", int'(overrun), int'(ovr_expect));
            // inputs wander mid-frame; only the snapshot may be used
            hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom); pm = 1'($urandom);
            if (k == rst_idx) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst tx_valid", int'(tx_valid), 0);
                chk("rst tx_last", int'(tx_last), 0);
                chk("rst busy", int'(busy), 0);
                chk("rst overrun", int'(overrun), 0);
                aborted = 1;
                break;
            end
            if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
            else if (k == stall_idx && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else tx_ready = 1'b1;
            start = 1'b0;
            if (k == ovr_idx && !ovr_done) begin
                start = 1'b1;
                ovr_done = 1;
            end
            if (ovr_last && k == N - 1 && tx_ready) start = 1'b1;
            ovr_expect = start;
            xfer = tx_ready;
            tick();
            start = 1'b0;
            cycles++;
            if (xfer) k++;
        end
        if (!aborted) begin
            chk("frame within budget", int'(cycles < LIMIT), 1);
            chk("end busy", int'(busy), 0);
            chk("end tx_valid", int'(tx_valid), 0);
            chk("end tx_last", int'(tx_last), 0);
            chk("end overrun", int'(overrun), int'(ovr_expect));
            tick();
            chk("idle busy", int'(busy), 0);
            chk("idle overrun", int'(overrun), 0);
        end
    endtask

    initial begin
        int cyc;
        int hv, mv, sv;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b1;
        hh = 8'h00; mm = 8'h00; ss = 8'h00; pm = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset tx_valid", int'(tx_valid), 0);
        chk("reset tx_last", int'(tx_last), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset tx_data", int'(tx_data), 0);
        tick();

        run_frame(8'h12, 8'h00, 8'h00, 1'b0, 0, -1, -1, 0, -1, cyc);
        chk("midnight cycles", cyc, N);

        run_frame(8'h09, 8'h05, 8'h59, 1'b1, 0, -1, -1, 0, -1, cyc);
        chk("leading zero cycles", cyc, N);

        run_frame(8'h12, 8'h30, 8'h45, 1'b0, 0, 4, -1, 0, -1, cyc);
        chk("backpressure cycles", cyc, N + 3);

        run_frame(8'h07, 8'h41, 8'h22, 1'b1, 0, -1, 6, 1, -1, cyc);
        chk("overrun frame cycles", cyc, N);

        run_frame(8'h1A, 8'h3C, 8'hF9, 1'b0, 0, -1, -1, 0, 7, cyc);
        tick();
        chk("after reset idle", int'(busy), 0);
        run_frame(8'h12, 8'h00, 8'h00, 1'b0, 0, -1, -1, 0, -1, cyc);
        chk("fresh frame cycles", cyc, N);

        for (int i = 0; i < 8; i++) begin
            hv = $urandom_range(1, 12);
            mv = $urandom_range(0, 59);
            sv = $urandom_range(0, 59);
            run_frame(8'(((hv / 10) << 4) | (hv % 10)), 8'(((mv / 10) << 4) | (mv % 10)),
                      8'(((sv / 10) << 4) | (sv % 10)), 1'($urandom), 1,
                      -1, (i % 2 == 0) ? int'($urandom_range(0, N - 1)) : -1, 0, -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
